// File: rtl/op_ctrl_pkg.sv
// Shared types for the affine schedule controller: FSM state encoding and
// the default iteration-vector layout {dim2, dim1, dim0}.
package op_ctrl_pkg;

  localparam int DEFAULT_CW = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } ctrl_state_t;

  typedef logic [2:0][DEFAULT_CW-1:0] ctrl_vec_t;

endpackage

// File: rtl/op_ctrl_dim_counter.sv
// One loop dimension of the odometer: counts 0..extent and wraps to 0,
// pulsing wrap on the increment that rolls over so the next dimension advances.
module op_ctrl_dim_counter
  import op_ctrl_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  // Last index of this dimension (trip count - 1), so a full 2^CW range fits.
  input  logic [CW-1:0] extent,
  output logic [CW-1:0] val,
  output logic          wrap
);

  logic [CW-1:0] val_q;
  logic          at_last;

  assign at_last = (val_q == extent);
  assign wrap    = inc & at_last;
  assign val     = val_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val_q <= '0;
    end else if (inc) begin
      val_q <= at_last ? '0 : val_q + CW'(1);
    end
  end

endmodule

// File: rtl/op_ctrl_affine_gen.sv
// Affine loop-nest controller for one unified-buffer port: waits START_CYCLE,
// then issues one iteration of a 3-deep nest every II cycles and flags done.
module op_ctrl_affine_gen
  import op_ctrl_pkg::*;
#(
  parameter int CW          = DEFAULT_CW,
  parameter int EXTENT_0    = 1,
  parameter int EXTENT_2    = 64,
  parameter int EXTENT_1    = 64,
  parameter int II          = 1,
  parameter int START_CYCLE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall,
  output logic                valid,
  output logic [2:0][CW-1:0]  ctrl_vars,
  output logic                done
);

  localparam logic [CW-1:0] LAST_0  = CW'(EXTENT_0 - 1);
  localparam logic [CW-1:0] LAST_1  = CW'(EXTENT_1 - 1);
  localparam logic [CW-1:0] LAST_2  = CW'(EXTENT_2 - 1);
  localparam logic [CW-1:0] II_M1   = CW'(II - 1);
  localparam logic [CW-1:0] START_C = CW'(START_CYCLE);

  ctrl_state_t   state_q;
  logic [CW-1:0] delay_q;
  logic [CW-1:0] ii_q;
  logic          done_q;

  logic issue;
  logic last;
  logic wrap1, wrap2, wrap0_unused;

  assign valid = (state_q == RUN) && (ii_q == '0) && !stall;
  assign issue = valid;
  assign done  = done_q;
  assign last  = (ctrl_vars[1] == LAST_1) && (ctrl_vars[2] == LAST_2) &&
                 (ctrl_vars[0] == LAST_0);

  // The final issue is kept from advancing the odometer so the last vector stays visible.
  op_ctrl_dim_counter #(.CW(CW)) u_dim1 (
    .clk(clk), .rst(rst), .clr(flush), .inc(issue & ~last),
    .extent(LAST_1), .val(ctrl_vars[1]), .wrap(wrap1)
  );

  op_ctrl_dim_counter #(.CW(CW)) u_dim2 (
    .clk(clk), .rst(rst), .clr(flush), .inc(wrap1),
    .extent(LAST_2), .val(ctrl_vars[2]), .wrap(wrap2)
  );

  op_ctrl_dim_counter #(.CW(CW)) u_dim0 (
    .clk(clk), .rst(rst), .clr(flush), .inc(wrap2),
    .extent(LAST_0), .val(ctrl_vars[0]), .wrap(wrap0_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      delay_q <= '0;
      ii_q    <= '0;
      done_q  <= 1'b0;
    end else if (flush) begin
      delay_q <= START_C;
      ii_q    <= '0;
      done_q  <= 1'b0;
      state_q <= (START_CYCLE == 0) ? RUN : DELAY;
    end else if (!stall) begin
      unique case (state_q)
        DELAY: begin
          delay_q <= delay_q - CW'(1);
          if (delay_q == CW'(1)) state_q <= RUN;
        end
        RUN: begin
          if (issue) begin
            ii_q <= II_M1;
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (ii_q != '0) begin
            ii_q <= ii_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_ctrl_affine_gen.sv
// Directed bench for op_ctrl_affine_gen: several configurations driven by a
// linear sequence of steps, expectations worked out by hand from the schedule.
module tb_op_ctrl_affine_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_flush, a_stall, a_valid, a_done;
  logic b_rst, b_flush, b_stall, b_valid, b_done;
  logic c_rst, c_flush, c_stall, c_valid, c_done;
  logic d_rst, d_flush, d_stall, d_valid, d_done;
  op_ctrl_pkg::ctrl_vec_t a_vars, b_vars, c_vars;
  logic [2:0][1:0] d_vars;

  int vecs = 0;
  int errs = 0;
  int restart_issues;

  op_ctrl_affine_gen #(.CW(16), .EXTENT_0(1), .EXTENT_2(2), .EXTENT_1(4), .II(1), .START_CYCLE(3)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .stall(a_stall),
    .valid(a_valid), .ctrl_vars(a_vars), .done(a_done));

  op_ctrl_affine_gen #(.CW(16), .EXTENT_0(1), .EXTENT_2(2), .EXTENT_1(4), .II(3), .START_CYCLE(3)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .stall(b_stall),
    .valid(b_valid), .ctrl_vars(b_vars), .done(b_done));

  op_ctrl_affine_gen #(.CW(16), .EXTENT_0(2), .EXTENT_2(2), .EXTENT_1(2), .II(1), .START_CYCLE(0)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .stall(c_stall),
    .valid(c_valid), .ctrl_vars(c_vars), .done(c_done));

  // Full 2^CW extent on the innermost dimension.
  op_ctrl_affine_gen #(.CW(2), .EXTENT_0(1), .EXTENT_2(1), .EXTENT_1(4), .II(1), .START_CYCLE(0)) u_d (
    .clk(clk), .rst(d_rst), .flush(d_flush), .stall(d_stall),
    .valid(d_valid), .ctrl_vars(d_vars), .done(d_done));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input op_ctrl_pkg::ctrl_vec_t v,
                         input int idx, input int e1, input int e2);
    chk({tag, ".dim1"}, 32'(v[1]), idx % e1);
    chk({tag, ".dim2"}, 32'(v[2]), (idx / e1) % e2);
    chk({tag, ".dim0"}, 32'(v[0]), idx / (e1 * e2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {a_rst, b_rst, c_rst, d_rst}         = 4'hf;
    {a_flush, b_flush, c_flush, d_flush} = 4'h0;
    {a_stall, b_stall, c_stall, d_stall} = 4'h0;

    // Reset state
    step(); step(); #1;
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_done", 32'(a_done), 0);
    chk_vec("rst_vec", a_vars, 0, 4, 2);
    chk("rst_d_valid", 32'(d_valid), 0);
    step();
    {a_rst, b_rst, c_rst, d_rst} = 4'h0;
    step(); #1;
    chk("idle_valid", 32'(a_valid), 0);

    // A: II=1, START=3 -> valid 4..11, done from 12
    step(); a_flush = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step(); a_flush = 1'b0; #1;
      chk("t1_valid", 32'(a_valid), 32'(c >= 4 && c <= 11));
      chk("t1_done", 32'(a_done), 32'(c >= 12));
      chk_vec("t1_vec", a_vars, (c < 4) ? 0 : ((c > 11) ? 7 : c - 4), 4, 2);
    end

    // B: II=3 -> valid 4,7,..,25, vector stable between issues, done from 26
    step(); b_flush = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      step(); b_flush = 1'b0; #1;
      chk("t2_valid", 32'(b_valid), 32'(c >= 4 && c <= 25 && ((c - 4) % 3 == 0)));
      chk("t2_done", 32'(b_done), 32'(c >= 26));
      chk_vec("t2_vec", b_vars, (c < 4) ? 0 : ((c > 25) ? 7 : (c - 2) / 3), 4, 2);
    end

    // A: stall in cycles 6-7 pushes the rest back by two
    step(); a_flush = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step(); a_flush = 1'b0; a_stall = (c == 6 || c == 7); #1;
      chk("t3_valid", 32'(a_valid), 32'((c >= 4 && c <= 5) || (c >= 8 && c <= 13)));
      chk("t3_done", 32'(a_done), 32'(c >= 14));
      chk_vec("t3_vec", a_vars,
              (c < 4) ? 0 : (c <= 5) ? c - 4 : (c <= 7) ? 2 : (c <= 13) ? c - 6 : 7, 4, 2);
    end

    // A: flush again in cycle 7 while running
    restart_issues = 0;
    step(); a_flush = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step(); a_flush = (c == 7); #1;
      if (c >= 8 && a_valid) restart_issues++;
      if (c != 7) begin
        chk("t4_valid", 32'(a_valid), 32'((c >= 4 && c <= 6) || (c >= 11 && c <= 18)));
        chk("t4_done", 32'(a_done), 32'(c >= 19));
        chk_vec("t4_vec", a_vars,
                (c < 4) ? 0 : (c <= 6) ? c - 4 : (c <= 10) ? 0 : (c <= 18) ? c - 11 : 7, 4, 2);
      end
    end
    chk("t4_restart_issues", restart_issues, 8);

    // A: rst in DELAY, later flush together with stall, stall held in DELAY
    step(); a_flush = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      a_flush = (c == 6);
      a_stall = (c >= 6 && c <= 9);
      a_rst   = (c == 2);
      #1;
      if (c == 1) chk("t5_done_cleared", 32'(a_done), 0);
      if (c >= 3) begin
        chk("t5_valid", 32'(a_valid), 32'(c >= 13));
        chk("t5_done", 32'(a_done), 0);
        chk_vec("t5_vec", a_vars, (c < 13) ? 0 : c - 13, 4, 2);
      end
    end
    a_stall = 1'b0;
    a_rst   = 1'b0;

    // C: 2x2x2, START=0 -> valid 1..8, dim0 steps after 4 issues, done from 9
    step(); c_flush = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step(); c_flush = 1'b0; #1;
      chk("t6_valid", 32'(c_valid), 32'(c <= 8));
      chk("t6_done", 32'(c_done), 32'(c >= 9));
      chk_vec("t6_vec", c_vars, (c <= 8) ? c - 1 : 7, 2, 2);
    end

    // C: flush on the same edge as the final issue restarts without done
    step(); c_flush = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step(); c_flush = (c == 8); #1;
      chk("t7_valid", 32'(c_valid), 1);
      chk("t7_done", 32'(c_done), 0);
      chk_vec("t7_vec", c_vars, (c == 9) ? 0 : c - 1, 2, 2);
    end
    c_flush = 1'b0;

    // D: innermost extent of 2^CW wraps through 0
    step(); d_flush = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(); d_flush = 1'b0; #1;
      chk("t8_valid", 32'(d_valid), 32'(c <= 4));
      chk("t8_done", 32'(d_done), 32'(c >= 5));
      chk("t8_dim1", 32'(d_vars[1]), (c <= 4) ? c - 1 : 3);
      chk("t8_dim2", 32'(d_vars[2]), 0);
      chk("t8_dim0", 32'(d_vars[0]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
